// File: rtl/regfile_pkg.sv
// Shared types, constants and the write-port priority helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;
  localparam int MAX_PORTS      = 8;
  localparam int PORT_IDX_W     = 3;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  // Index of the highest set bit in match; callers qualify the result with |match.
  function automatic logic [PORT_IDX_W-1:0] win_port(input logic [MAX_PORTS-1:0] match);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int j = 0; j < MAX_PORTS; j++) begin
      if (match[j]) begin
        idx = PORT_IDX_W'(j);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: issue sets busy, writeback clears it, issue wins a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic [2**ADDR_WIDTH-1:0]     busy,
  output logic                         any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [DEPTH-1:0] clr_s;
  logic             any_busy_r;

  // Collect writeback clears per register address.
  always_comb begin
    clr_s = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a))) begin
          clr_s[a] = 1'b1;
        end else begin
          clr_s[a] = clr_s[a];
        end
      end
    end
  end

  // Next busy state; register 0 is held permanently idle.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int a = 1; a < DEPTH; a++) begin
      if (iss_en && (iss_addr == ADDR_WIDTH'(a))) begin
        busy_nxt_s[a] = 1'b1;
      end else if (clr_s[a]) begin
        busy_nxt_s[a] = 1'b0;
      end else begin
        busy_nxt_s[a] = busy_r[a];
      end
    end
    busy_nxt_s[REG_ZERO] = 1'b0;
  end

  // Busy vector and its OR, both registered so any_busy tracks busy exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r     <= '0;
      any_busy_r <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      any_busy_r <= |busy_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign any_busy = any_busy_r;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with pending-write scoreboard.
// Optional same-cycle write-through on reads: define REGFILE_BYPASS_EN.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic                         any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      busy_s;

  // Storage write; later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_r[a] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO))) begin
          mem_r[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign ra_s = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REGFILE_BYPASS_EN
    logic [MAX_PORTS-1:0] hit_s;

    // Write ports addressing this read port's register in the current cycle.
    always_comb begin
      hit_s = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        hit_s[j] = wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra_s);
      end
    end

    // Read mux: zero register, then forwarded write data, then storage.
    always_comb begin
      if (ra_s == ADDR_WIDTH'(REG_ZERO)) begin
        data_s = '0;
      end else if (|hit_s) begin
        data_s = wr_data[int'(win_port(hit_s))*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        data_s = mem_r[ra_s];
      end
    end
`else
    // Read mux: zero register, otherwise storage.
    always_comb begin
      if (ra_s == ADDR_WIDTH'(REG_ZERO)) begin
        data_s = '0;
      end else begin
        data_s = mem_r[ra_s];
      end
    end
`endif

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_s;
    assign rd_busy[i]                          = busy_s[ra_s];
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy     (busy_s),
    .any_busy (any_busy)
  );

endmodule
